// File: rtl/led_afterglow.sv
// Per-channel LED afterglow: lit LEDs jump to full brightness and fade
// one level per decay tick, rendered through a shared 16-step PWM.
module led_afterglow #(
   parameter logic [25:0] DECAY_DIV = 26'd1250000,
   parameter int          N_LED     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_LED-1:0] pat_in,
   output logic [N_LED-1:0] led_out,
   output logic             glow_any,
   output logic             tick
);

   logic [3:0]  lvl [N_LED];
   logic [25:0] div_cnt;
   logic [3:0]  pwm_cnt;
   logic        wrap;
   logic        any_lit;

   assign wrap = (div_cnt == DECAY_DIV - 26'd1);

   always_comb begin
      any_lit = 1'b0;
      for (int i = 0; i < N_LED; i++)
         if (lvl[i] != 4'd0) any_lit = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         pwm_cnt  <= '0;
         tick     <= 1'b0;
         glow_any <= 1'b0;
         led_out  <= '0;
         for (int i = 0; i < N_LED; i++) lvl[i] <= 4'd0;
      end else begin
         tick     <= en && wrap;
         glow_any <= any_lit;
         if (en) begin
            div_cnt <= wrap ? 26'd0 : div_cnt + 26'd1;
            pwm_cnt <= pwm_cnt + 4'd1;
            // reload beats decrement when both land on the same cycle
            for (int i = 0; i < N_LED; i++) begin
               if (pat_in[i])
                  lvl[i] <= 4'd15;
               else if (tick && lvl[i] != 4'd0)
                  lvl[i] <= lvl[i] - 4'd1;
            end
         end
         for (int i = 0; i < N_LED; i++)
            led_out[i] <= en && (lvl[i] > pwm_cnt);
      end
   end

endmodule
